// File: rtl/riot_pkg.sv
// Shared constants and types for the RIOT-style port/timer block.
package riot_pkg;

  // Address bit positions used by the register decoder
  localparam int A_SEL_TIMER = 4;
  localparam int A_SEL_EDGE  = 2;
  localparam int A_IE        = 3;

  // Bit positions inside the flag register read
  localparam int FLAG_TIMER_BIT = 7;
  localparam int FLAG_EDGE_BIT  = 6;

  // Prescaler selection, taken from A[1:0] on a timer write
  typedef enum logic [1:0] {
    PS_1    = 2'd0,
    PS_8    = 2'd1,
    PS_64   = 2'd2,
    PS_1024 = 2'd3
  } ps_sel_t;

  // Largest of four values, used to size the prescale counter
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/riot_ports_timer_if.sv
// 6502-side register bus of the RIOT port/timer block.
interface riot_ports_timer_if;
  logic       cs;
  logic       we_n;
  logic [4:0] A;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       OE;

  modport master (output cs, output we_n, output A, output DI, input DO, input OE);
  modport slave  (input cs, input we_n, input A, input DI, output DO, output OE);
endinterface

// File: rtl/riot_interval_timer.sv
// Interval timer: prescaler, down counter and underflow flag.
// After an underflow the prescaler is bypassed (free-run at /1) until reloaded.
module riot_interval_timer
  import riot_pkg::*;
#(
  parameter int TIMER_W   = 8,
  parameter int PS_SHIFT0 = 0,
  parameter int PS_SHIFT1 = 3,
  parameter int PS_SHIFT2 = 6,
  parameter int PS_SHIFT3 = 10
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  ps_sel_t    load_sel,
  input  logic       read_clr,
  output logic [7:0] count_lo,
  output logic       flag,
  output logic       flag_next
);

  localparam int MAX_SHIFT = max4(PS_SHIFT0, PS_SHIFT1, PS_SHIFT2, PS_SHIFT3);
  localparam int PSC_W     = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;

  logic [TIMER_W-1:0] count_q, count_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [PSC_W-1:0]   psc_mask;
  ps_sel_t            sel_q, sel_d;
  logic               free_run_q, free_run_d;
  logic               flag_q, flag_d;
  logic               tick;
  logic               underflow;
  int                 shift;

  // Terminal prescale count for the selected divider (zero while free-running)
  always_comb begin
    shift = PS_SHIFT0;
    case (sel_q)
      PS_1:    shift = PS_SHIFT0;
      PS_8:    shift = PS_SHIFT1;
      PS_64:   shift = PS_SHIFT2;
      PS_1024: shift = PS_SHIFT3;
      default: shift = PS_SHIFT0;
    endcase
    psc_mask = free_run_q ? '0 : ~({PSC_W{1'b1}} << shift);
  end

  assign tick      = (psc_q >= psc_mask);
  assign underflow = tick & (count_q == '0);

  // Next state: count/underflow first, then flag clear/set, and a load overrides all
  always_comb begin
    psc_d      = tick ? '0 : psc_q + PSC_W'(1);
    count_d    = tick ? count_q - TIMER_W'(1) : count_q;
    free_run_d = free_run_q | underflow;
    sel_d      = sel_q;
    flag_d     = flag_q;
    if (read_clr && flag_q) flag_d = 1'b0;
    if (underflow)          flag_d = 1'b1;
    if (load) begin
      count_d    = TIMER_W'(load_val);
      psc_d      = '0;
      free_run_d = 1'b0;
      flag_d     = 1'b0;
      sel_d      = load_sel;
    end
  end

  // State registers
  always_ff @(posedge phi2) begin
    if (rst) begin
      count_q    <= '0;
      psc_q      <= '0;
      sel_q      <= PS_1;
      free_run_q <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      psc_q      <= psc_d;
      sel_q      <= sel_d;
      free_run_q <= free_run_d;
      flag_q     <= flag_d;
    end
  end

  assign count_lo  = count_q[7:0];
  assign flag      = flag_q;
  assign flag_next = flag_d;

endmodule

// File: rtl/riot_ports_timer.sv
// RIOT-style I/O block: parametrised ports with DDRs, an interval timer,
// an edge detector on one port-0 pin, and a combined active-low interrupt.
module riot_ports_timer
  import riot_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 8,
  parameter int TIMER_W   = 8,
  parameter int PS_SHIFT0 = 0,
  parameter int PS_SHIFT1 = 3,
  parameter int PS_SHIFT2 = 6,
  parameter int PS_SHIFT3 = 10,
  parameter int EDGE_BIT  = 7
) (
  input  logic                        phi2,
  input  logic                        rst,
  riot_ports_timer_if.slave           bus,
  output logic [NUM_PORTS*PORT_W-1:0] port_out,
  input  logic [NUM_PORTS*PORT_W-1:0] port_in,
  output logic [NUM_PORTS*PORT_W-1:0] port_ddr,
  output logic                        irq_n
);

  // Narrow ports cannot hold bit 7; fall back to their top bit instead
  localparam int EDGE_IDX = (EDGE_BIT < PORT_W) ? EDGE_BIT : PORT_W - 1;

  logic [PORT_W-1:0] port_out_q [NUM_PORTS];
  logic [PORT_W-1:0] port_out_d [NUM_PORTS];
  logic [PORT_W-1:0] ddr_q      [NUM_PORTS];
  logic [PORT_W-1:0] ddr_d      [NUM_PORTS];
  logic [PORT_W-1:0] eff_port   [NUM_PORTS];

  logic       timer_ie_q, timer_ie_d;
  logic       edge_ie_q, edge_ie_d;
  logic       edge_pol_q, edge_pol_d;
  logic       edge_flag_q, edge_flag_d;
  logic       edge_prev_q, edge_prev_d;
  logic [7:0] do_q, do_d;
  logic       oe_q, oe_d;
  logic       irq_n_q, irq_n_d;

  logic              rd, wr;
  logic [2:0]        idx;
  logic              timer_acc, edge_acc;
  logic              timer_load, timer_rd, status_rd;
  logic              edge_cur, new_edge;
  logic [PORT_W-1:0] port_rd;
  logic [7:0]        rd_data;
  logic [7:0]        timer_lo;
  logic              timer_flag, timer_flag_next;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_out[p*PORT_W +: PORT_W] = port_out_q[p];
    assign port_ddr[p*PORT_W +: PORT_W] = ddr_q[p];
    assign eff_port[p] = (ddr_q[p] & port_out_q[p]) | (~ddr_q[p] & port_in[p*PORT_W +: PORT_W]);
  end

  assign rd         = bus.cs & bus.we_n;
  assign wr         = bus.cs & ~bus.we_n;
  assign idx        = bus.A[3:1];
  assign timer_acc  = bus.A[A_SEL_TIMER] & ~bus.A[A_SEL_EDGE];
  assign edge_acc   = bus.A[A_SEL_TIMER] & bus.A[A_SEL_EDGE];
  assign timer_load = wr & timer_acc;
  assign timer_rd   = rd & timer_acc & ~bus.A[0];
  assign status_rd  = rd & timer_acc & bus.A[0];

  assign edge_cur = eff_port[0][EDGE_IDX];
  assign new_edge = edge_pol_q ? (~edge_prev_q & edge_cur) : (edge_prev_q & ~edge_cur);

  riot_interval_timer #(
    .TIMER_W  (TIMER_W),
    .PS_SHIFT0(PS_SHIFT0),
    .PS_SHIFT1(PS_SHIFT1),
    .PS_SHIFT2(PS_SHIFT2),
    .PS_SHIFT3(PS_SHIFT3)
  ) u_timer (
    .phi2     (phi2),
    .rst      (rst),
    .load     (timer_load),
    .load_val (bus.DI),
    .load_sel (ps_sel_t'(bus.A[1:0])),
    .read_clr (timer_rd),
    .count_lo (timer_lo),
    .flag     (timer_flag),
    .flag_next(timer_flag_next)
  );

  // Read data mux; unimplemented port indices fall through to zero
  always_comb begin
    port_rd = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (idx == 3'(p)) port_rd = bus.A[0] ? ddr_q[p] : eff_port[p];
    end
    rd_data = 8'h00;
    if (!bus.A[A_SEL_TIMER]) begin
      rd_data = 8'(port_rd);
    end else if (bus.A[A_SEL_EDGE]) begin
      rd_data = {6'b0, edge_ie_q, edge_pol_q};
    end else if (bus.A[0]) begin
      rd_data[FLAG_TIMER_BIT] = timer_flag;
      rd_data[FLAG_EDGE_BIT]  = edge_flag_q;
    end else begin
      rd_data = timer_lo;
    end
  end

  // Register writes, edge flag precedence, read capture and interrupt
  always_comb begin
    port_out_d  = port_out_q;
    ddr_d       = ddr_q;
    timer_ie_d  = timer_ie_q;
    edge_ie_d   = edge_ie_q;
    edge_pol_d  = edge_pol_q;
    edge_flag_d = edge_flag_q;
    edge_prev_d = edge_cur;
    do_d        = do_q;
    oe_d        = 1'b0;

    if (wr && !bus.A[A_SEL_TIMER]) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (idx == 3'(p)) begin
          if (bus.A[0]) ddr_d[p]      = bus.DI[PORT_W-1:0];
          else          port_out_d[p] = bus.DI[PORT_W-1:0];
        end
      end
    end

    if (timer_load || timer_rd) timer_ie_d = bus.A[A_IE];

    if (wr && edge_acc) begin
      edge_pol_d = bus.A[0];
      edge_ie_d  = bus.A[1];
    end

    if (status_rd && edge_flag_q) edge_flag_d = 1'b0;
    if (new_edge)                 edge_flag_d = 1'b1;

    if (rd) begin
      oe_d = 1'b1;
      do_d = rd_data;
    end

    irq_n_d = ~((timer_flag_next & timer_ie_d) | (edge_flag_d & edge_ie_d));
  end

  // State registers
  always_ff @(posedge phi2) begin
    if (rst) begin
      port_out_q  <= '{default: '0};
      ddr_q       <= '{default: '0};
      timer_ie_q  <= 1'b0;
      edge_ie_q   <= 1'b0;
      edge_pol_q  <= 1'b0;
      edge_flag_q <= 1'b0;
      edge_prev_q <= 1'b0;
      do_q        <= 8'h00;
      oe_q        <= 1'b0;
      irq_n_q     <= 1'b1;
    end else begin
      port_out_q  <= port_out_d;
      ddr_q       <= ddr_d;
      timer_ie_q  <= timer_ie_d;
      edge_ie_q   <= edge_ie_d;
      edge_pol_q  <= edge_pol_d;
      edge_flag_q <= edge_flag_d;
      edge_prev_q <= edge_prev_d;
      do_q        <= do_d;
      oe_q        <= oe_d;
      irq_n_q     <= irq_n_d;
    end
  end

  assign bus.DO = do_q;
  assign bus.OE = oe_q;
  assign irq_n  = irq_n_q;

endmodule

// File: tb/tb_riot_ports_timer.sv
// Testbench for riot_ports_timer: default instance plus a 4x6-bit, 12-bit-timer instance.
// Reads push their expected data into a per-instance queue; a forked monitor
// pops and compares whenever OE is high.
module tb_riot_ports_timer;

  logic phi2 = 1'b0;
  logic rst  = 1'b1;

  // Free-running bus clock
  always #5 phi2 = ~phi2;

  riot_ports_timer_if bus0 ();
  riot_ports_timer_if bus1 ();

  logic [15:0] port_out0, port_in0, port_ddr0;
  logic        irq_n0;
  logic [23:0] port_out1, port_in1, port_ddr1;
  logic        irq_n1;

  riot_ports_timer dut0 (
    .phi2    (phi2),
    .rst     (rst),
    .bus     (bus0),
    .port_out(port_out0),
    .port_in (port_in0),
    .port_ddr(port_ddr0),
    .irq_n   (irq_n0)
  );

  riot_ports_timer #(
    .NUM_PORTS(4),
    .PORT_W   (6),
    .TIMER_W  (12)
  ) dut1 (
    .phi2    (phi2),
    .rst     (rst),
    .bus     (bus1),
    .port_out(port_out1),
    .port_in (port_in1),
    .port_ddr(port_ddr1),
    .irq_n   (irq_n1)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks = 0;
  int   errors = 0;

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitorStep();
    exp_t e;
    if (bus0.OE === 1'b1) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("[TB] FAIL u0_unexpected_read actual=%h required=none", bus0.DO);
      end else begin
        e = exp_q0.pop_front();
        if (bus0.DO !== e.val) begin
          errors++;
          $display("[TB] FAIL %s actual=%h required=%h", e.name, bus0.DO, e.val);
        end
      end
    end
    if (bus1.OE === 1'b1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("[TB] FAIL u1_unexpected_read actual=%h required=none", bus1.DO);
      end else begin
        e = exp_q1.pop_front();
        if (bus1.DO !== e.val) begin
          errors++;
          $display("[TB] FAIL %s actual=%h required=%h", e.name, bus1.DO, e.val);
        end
      end
    end
  endtask

  // One bus cycle on unit 0 or 1; a read also queues its expected data
  task automatic applyStimulus(input int unit, input logic wr, input logic [4:0] a,
                               input logic [7:0] d, input string name);
    exp_t e;
    @(negedge phi2);
    e.name = name;
    e.val  = d;
    if (unit == 0) begin
      if (!wr) exp_q0.push_back(e);
      bus0.cs = 1'b1; bus0.we_n = ~wr; bus0.A = a; bus0.DI = wr ? d : 8'h00;
    end else begin
      if (!wr) exp_q1.push_back(e);
      bus1.cs = 1'b1; bus1.we_n = ~wr; bus1.A = a; bus1.DI = wr ? d : 8'h00;
    end
    @(posedge phi2);
    #1;
    bus0.cs = 1'b0; bus0.we_n = 1'b1;
    bus1.cs = 1'b0; bus1.we_n = 1'b1;
  endtask

  task automatic busWrite(input int unit, input logic [4:0] a, input logic [7:0] d);
    applyStimulus(unit, 1'b1, a, d, "write");
  endtask

  task automatic busRead(input int unit, input logic [4:0] a, input logic [7:0] exp, input string name);
    applyStimulus(unit, 1'b0, a, exp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge phi2);
    #1;
  endtask

  // Stimulus with a forked scoreboard monitor
  initial begin
    bus0.cs = 1'b0; bus0.we_n = 1'b1; bus0.A = 5'd0; bus0.DI = 8'h00;
    bus1.cs = 1'b0; bus1.we_n = 1'b1; bus1.A = 5'd0; bus1.DI = 8'h00;
    port_in0 = 16'h0000;
    port_in1 = 24'h000000;

    fork
      forever begin
        @(negedge phi2);
        monitorStep();
      end
    join_none

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge phi2);
    #1;
    rst = 1'b0;
    checkOutput("rst_port_out", 32'(port_out0), 32'h0);
    checkOutput("rst_port_ddr", 32'(port_ddr0), 32'h0);
    checkOutput("rst_irq_n", 32'(irq_n0), 32'h1);
    checkOutput("rst_oe", 32'(bus0.OE), 32'h0);
    checkOutput("rst_irq_n_u1", 32'(irq_n1), 32'h1);
    busRead(0, 5'b10001, 8'h00, "rst_flags");
    busWrite(0, 5'b10011, 8'hFF);

    // Rising edge detector with interrupt enabled
    busWrite(0, 5'b10111, 8'h00);
    busRead(0, 5'b10100, 8'h03, "edge_cfg");
    port_in0[7] = 1'b1;
    idle(1);
    checkOutput("edge_irq_low", 32'(irq_n0), 32'h0);
    busRead(0, 5'b10001, 8'h40, "edge_flag_read");
    checkOutput("edge_irq_cleared", 32'(irq_n0), 32'h1);
    busRead(0, 5'b10001, 8'h00, "edge_flag_gone");

    // Flag read colliding with a fresh edge: set wins
    port_in0[7] = 1'b0;
    idle(2);
    port_in0[7] = 1'b1;
    idle(2);
    checkOutput("edge_rearm_irq", 32'(irq_n0), 32'h0);
    port_in0[7] = 1'b0;
    idle(2);
    port_in0[7] = 1'b1;
    busRead(0, 5'b10001, 8'h40, "edge_collide_read");
    checkOutput("edge_collide_irq", 32'(irq_n0), 32'h0);
    busRead(0, 5'b10001, 8'h40, "edge_collide_kept");
    checkOutput("edge_collide_clr_irq", 32'(irq_n0), 32'h1);

    // Timer /8 with interrupt, then free-run at /1
    busWrite(0, 5'b11001, 8'h03);
    idle(31);
    checkOutput("timer_irq_before", 32'(irq_n0), 32'h1);
    idle(1);
    checkOutput("timer_irq_at_32", 32'(irq_n0), 32'h0);
    busRead(0, 5'b11000, 8'hFF, "timer_wrap_ff");
    busRead(0, 5'b11000, 8'hFE, "timer_freerun_fe");
    checkOutput("timer_irq_cleared", 32'(irq_n0), 32'h1);
    busRead(0, 5'b10001, 8'h00, "timer_flag_gone");

    // Timer write in the underflow cycle: the write wins
    busWrite(0, 5'b11000, 8'h00);
    busWrite(0, 5'b11011, 8'hFF);
    checkOutput("timer_collide_irq", 32'(irq_n0), 32'h1);
    busRead(0, 5'b10001, 8'h00, "timer_collide_flag");
    busRead(0, 5'b11000, 8'hFF, "timer_reload_val");

    // Ports, DDR mixing, invalid index, and a port write creating an edge
    port_in0 = 16'h003C;
    idle(2);
    busWrite(0, 5'b00001, 8'hF0);
    busWrite(0, 5'b00000, 8'hA5);
    busRead(0, 5'b00000, 8'hAC, "port0_eff");
    checkOutput("port0_out", 32'(port_out0[7:0]), 32'hA5);
    checkOutput("port0_ddr", 32'(port_ddr0[7:0]), 32'hF0);
    checkOutput("port_write_edge_irq", 32'(irq_n0), 32'h0);
    busRead(0, 5'b01010, 8'h00, "port_idx5");
    busRead(0, 5'b00001, 8'hF0, "ddr0_read");
    busRead(0, 5'b10001, 8'h40, "port_edge_flag");
    checkOutput("port_edge_irq_clr", 32'(irq_n0), 32'h1);
    busWrite(0, 5'b00011, 8'hFF);
    busWrite(0, 5'b00010, 8'h5A);
    busRead(0, 5'b00010, 8'h5A, "port1_read");
    busWrite(0, 5'b01010, 8'hFF);
    checkOutput("ports_out_all", 32'(port_out0), 32'h5AA5);
    checkOutput("ports_ddr_all", 32'(port_ddr0), 32'hFFF0);

    // Reset in the middle of activity
    @(negedge phi2);
    rst = 1'b1;
    @(posedge phi2);
    #1;
    rst = 1'b0;
    checkOutput("midrst_port_out", 32'(port_out0), 32'h0);
    checkOutput("midrst_port_ddr", 32'(port_ddr0), 32'h0);
    checkOutput("midrst_irq_n", 32'(irq_n0), 32'h1);
    checkOutput("midrst_oe", 32'(bus0.OE), 32'h0);
    busRead(0, 5'b10001, 8'h00, "midrst_flags");
    busRead(0, 5'b10100, 8'h00, "midrst_edge_cfg");

    // Parametrised instance: 6-bit ports, 4 ports, 12-bit timer
    busWrite(1, 5'b00111, 8'hFF);
    busRead(1, 5'b00111, 8'h3F, "u1_ddr3_ff");
    busWrite(1, 5'b00111, 8'hC5);
    busRead(1, 5'b00111, 8'h05, "u1_ddr3_c5");
    checkOutput("u1_ddr3_pins", 32'(port_ddr1[23:18]), 32'h05);
    busRead(1, 5'b01010, 8'h00, "u1_idx5");
    busWrite(1, 5'b11000, 8'h00);
    idle(1);
    checkOutput("u1_timer_irq", 32'(irq_n1), 32'h0);
    busRead(1, 5'b11000, 8'hFF, "u1_timer_wrap");
    checkOutput("u1_timer_irq_clr", 32'(irq_n1), 32'h1);
    idle(300);
    busRead(1, 5'b10001, 8'h00, "u1_timer_12bit");
    checkOutput("u1_timer_12bit_irq", 32'(irq_n1), 32'h1);

    idle(3);
    checkOutput("sb0_drained", 32'(exp_q0.size()), 32'h0);
    checkOutput("sb1_drained", 32'(exp_q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
